// File: rtl/layer_2_channel_packer.sv
// layer_2_channel_packer
//   Packs channel-serial samples from the layer-1 output into one wide word per pixel
//   for the layer-2 featuremap block. It tracks the pixel's row and column and flags
//   the end of each frame.
//
// Ports
//   Clk         rising-edge clock
//   Rst         asynchronous active-low reset
//   ch_data     one channel sample, passed through bit-exact
//   ch_valid    ch_data is valid this cycle; every valid word is accepted
//   ch_sof      ch_data is ch0 of pixel (0,0); only meaningful when ch_valid is high
//   data_out    packed pixel, channel k at [k*DATA_WIDTH +: DATA_WIDTH]; held between pulses
//   valid_out   one-cycle pulse: data_out carries a new pixel
//   col_out     column of the pixel on data_out
//   row_out     row of the pixel on data_out
//   frame_done  pulses together with valid_out for the last pixel of the frame
//   sync_err    sticky flag for a misaligned ch_sof; only reset clears it
module layer_2_channel_packer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 16,
  parameter int unsigned IMG_SIZE   = 208,
  localparam int unsigned CoordW    = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [DATA_WIDTH-1:0]        ch_data,
  input  logic                         ch_valid,
  input  logic                         ch_sof,
  output logic [DATA_WIDTH*NUM_CH-1:0] data_out,
  output logic                         valid_out,
  output logic [CoordW-1:0]            col_out,
  output logic [CoordW-1:0]            row_out,
  output logic                         frame_done,
  output logic                         sync_err
);

  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ChW-1:0]    LastCh  = ChW'(NUM_CH - 1);
  localparam logic [CoordW-1:0] LastPos = CoordW'(IMG_SIZE - 1);

  logic [ChW-1:0]                       ch_cnt_q, ch_cnt_d;
  logic [CoordW-1:0]                    col_q, col_d, row_q, row_d;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    shadow_q, shadow_d;
  logic [DATA_WIDTH*NUM_CH-1:0]         data_out_q, data_out_d;
  logic                                 valid_q, valid_d;
  logic [CoordW-1:0]                    col_out_q, col_out_d, row_out_q, row_out_d;
  logic                                 done_q, done_d;
  logic                                 err_q, err_d;

  logic                                 sof_bad;
  logic [ChW-1:0]                       cnt_eff;
  logic [CoordW-1:0]                    col_eff, row_eff;

  always_comb begin
    ch_cnt_d   = ch_cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    shadow_d   = shadow_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    col_out_d  = col_out_q;
    row_out_d  = row_out_q;
    done_d     = 1'b0;
    err_d      = err_q;

    // A start-of-frame marker anywhere but the very start of a pixel (0,0) realigns:
    // the partial pixel is dropped and this word becomes ch0 of pixel (0,0).
    sof_bad = ch_valid && ch_sof &&
              ((ch_cnt_q != '0) || (col_q != '0) || (row_q != '0));
    cnt_eff = sof_bad ? '0 : ch_cnt_q;
    col_eff = sof_bad ? '0 : col_q;
    row_eff = sof_bad ? '0 : row_q;

    if (ch_valid) begin
      shadow_d[cnt_eff] = ch_data;
      if (sof_bad) begin
        err_d = 1'b1;
      end
      if (cnt_eff == LastCh) begin
        ch_cnt_d   = '0;
        data_out_d = shadow_d;
        valid_d    = 1'b1;
        col_out_d  = col_eff;
        row_out_d  = row_eff;
        done_d     = (col_eff == LastPos) && (row_eff == LastPos);
        if (col_eff == LastPos) begin
          col_d = '0;
          row_d = (row_eff == LastPos) ? '0 : row_eff + CoordW'(1);
        end else begin
          col_d = col_eff + CoordW'(1);
          row_d = row_eff;
        end
      end else begin
        ch_cnt_d = cnt_eff + ChW'(1);
        col_d    = col_eff;
        row_d    = row_eff;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ch_cnt_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      shadow_q   <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      col_out_q  <= '0;
      row_out_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ch_cnt_q   <= ch_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      shadow_q   <= shadow_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      col_out_q  <= col_out_d;
      row_out_q  <= row_out_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign data_out   = data_out_q;
  assign valid_out  = valid_q;
  assign col_out    = col_out_q;
  assign row_out    = row_out_q;
  assign frame_done = done_q;
  assign sync_err   = err_q;

endmodule

// File: tb/tb_layer_2_channel_packer.sv
module tb_layer_2_channel_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Main instance: default 16 channels x 32 bits, 208x208.
  logic [31:0]  m_data = '0;
  logic         m_valid = 1'b0, m_sof = 1'b0;
  logic [511:0] m_dout;
  logic         m_vout, m_done, m_err;
  logic [7:0]   m_col, m_row;

  layer_2_channel_packer dut (
    .Clk(clk), .Rst(rst_n), .ch_data(m_data), .ch_valid(m_valid), .ch_sof(m_sof),
    .data_out(m_dout), .valid_out(m_vout), .col_out(m_col), .row_out(m_row),
    .frame_done(m_done), .sync_err(m_err)
  );

  // Single-channel instance over a full 208x208 frame (one word per pixel).
  logic [31:0] b_data = '0;
  logic        b_valid = 1'b0, b_sof = 1'b0;
  logic [31:0] b_dout;
  logic        b_vout, b_done, b_err;
  logic [7:0]  b_col, b_row;

  layer_2_channel_packer #(.DATA_WIDTH(32), .NUM_CH(1), .IMG_SIZE(208)) dut_big (
    .Clk(clk), .Rst(rst_n), .ch_data(b_data), .ch_valid(b_valid), .ch_sof(b_sof),
    .data_out(b_dout), .valid_out(b_vout), .col_out(b_col), .row_out(b_row),
    .frame_done(b_done), .sync_err(b_err)
  );

  // Small sweep instance: NUM_CH=1, IMG_SIZE=4.
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0, s_sof = 1'b0;
  logic [31:0] s_dout;
  logic        s_vout, s_done, s_err;
  logic [1:0]  s_col, s_row;

  layer_2_channel_packer #(.DATA_WIDTH(32), .NUM_CH(1), .IMG_SIZE(4)) dut_small (
    .Clk(clk), .Rst(rst_n), .ch_data(s_data), .ch_valid(s_valid), .ch_sof(s_sof),
    .data_out(s_dout), .valid_out(s_vout), .col_out(s_col), .row_out(s_row),
    .frame_done(s_done), .sync_err(s_err)
  );

  typedef struct {
    logic        v;
    logic        sof;
    logic [31:0] d;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  ec;
    logic [1:0]  er;
    logic        edone;
    logic        eerr;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic m_word(input logic [31:0] d, input logic sof);
    m_data  = d;
    m_valid = 1'b1;
    m_sof   = sof;
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    m_sof   = 1'b0;
  endtask

  function automatic logic [511:0] pack_seq(input logic [31:0] base);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = base + k;
    return r;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0] exp4;
    int early;
    int seq_err, pulses, dones;
    logic [7:0] c208, r208;

    // Reset state
    rst_n = 1'b0;
    #12;
    chk("rst_valid", m_vout, 0);
    chk("rst_data", m_dout, 0);
    chk("rst_col", m_col, 0);
    chk("rst_row", m_row, 0);
    chk("rst_done", m_done, 0);
    chk("rst_err", m_err, 0);
    do_reset();

    // 1: back-to-back pixel
    early = 0;
    for (int k = 0; k < 16; k++) begin
      m_word(32'h3F80_0000 + k, k == 0);
      if (k < 15 && m_vout !== 1'b0) early++;
    end
    chk("t1_no_early_pulse", early, 0);
    chk("t1_valid", m_vout, 1);
    chk("t1_ch0", m_dout[31:0], 32'h3F80_0000);
    chk("t1_ch15", m_dout[511:480], 32'h3F80_000F);
    chk("t1_data", m_dout, pack_seq(32'h3F80_0000));
    chk("t1_col", m_col, 0);
    chk("t1_row", m_row, 0);
    chk("t1_done", m_done, 0);
    chk("t1_err", m_err, 0);
    @(posedge clk);
    #1;
    chk("t1_pulse_width", m_vout, 0);
    chk("t1_data_hold", m_dout, pack_seq(32'h3F80_0000));

    // 2: same pixel with 3-cycle gaps
    do_reset();
    early = 0;
    for (int k = 0; k < 16; k++) begin
      m_word(32'h3F80_0000 + k, k == 0);
      if (m_vout !== (k == 15)) early++;
      if (k < 15) begin
        repeat (3) begin
          @(posedge clk);
          #1;
          if (m_vout !== 1'b0) early++;
        end
      end
    end
    chk("t2_no_gap_pulse", early, 0);
    chk("t2_valid", m_vout, 1);
    chk("t2_data", m_dout, pack_seq(32'h3F80_0000));
    chk("t2_col", m_col, 0);
    chk("t2_err", m_err, 0);

    // 4: misaligned sof after 5 words
    do_reset();
    for (int k = 0; k < 5; k++) m_word(32'hA000_0000 + k, k == 0);
    m_word(32'hB000_0000, 1'b1);
    chk("t4_err_set", m_err, 1);
    chk("t4_no_pulse", m_vout, 0);
    early = 0;
    for (int k = 1; k < 16; k++) begin
      m_word(32'hC000_0000 + k, 1'b0);
      if (k < 15 && m_vout !== 1'b0) early++;
    end
    exp4 = pack_seq(32'hC000_0000);
    exp4[31:0] = 32'hB000_0000;
    chk("t4_no_early_pulse", early, 0);
    chk("t4_valid", m_vout, 1);
    chk("t4_data", m_dout, exp4);
    chk("t4_col", m_col, 0);
    chk("t4_row", m_row, 0);
    chk("t4_err_sticky", m_err, 1);

    // 5: reset in the middle of pixel (3,0)
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 16; k++) m_word(32'h100 * p + k, (p == 0) && (k == 0));
    chk("t5_col2", m_col, 2);
    chk("t5_data_p2", m_dout, pack_seq(32'h200));
    for (int k = 0; k < 9; k++) m_word(32'h300 + k, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("t5_async_data", m_dout, 0);
    chk("t5_async_col", m_col, 0);
    chk("t5_async_valid", m_vout, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 16; k++) m_word(32'h900 + k, k == 0);
    chk("t5_valid", m_vout, 1);
    chk("t5_data", m_dout, pack_seq(32'h900));
    chk("t5_col", m_col, 0);
    chk("t5_row", m_row, 0);
    chk("t5_err", m_err, 0);

    // 6: NUM_CH=1, IMG_SIZE=4 table
    tbl[0]  = '{1'b1, 1'b1, 32'd0,  1'b1, 32'd0,  2'd0, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'd1,  1'b1, 32'd1,  2'd1, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'd2,  1'b1, 32'd2,  2'd2, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'd3,  1'b1, 32'd3,  2'd3, 2'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'd4,  1'b1, 32'd4,  2'd0, 2'd1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'd5,  1'b1, 32'd5,  2'd1, 2'd1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 32'd6,  1'b1, 32'd6,  2'd2, 2'd1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'd7,  1'b1, 32'd7,  2'd3, 2'd1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'd8,  1'b1, 32'd8,  2'd0, 2'd2, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'd9,  1'b1, 32'd9,  2'd1, 2'd2, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 32'd10, 1'b1, 32'd10, 2'd2, 2'd2, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 32'd11, 1'b1, 32'd11, 2'd3, 2'd2, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 32'd12, 1'b1, 32'd12, 2'd0, 2'd3, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 32'd13, 1'b1, 32'd13, 2'd1, 2'd3, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 32'd14, 1'b1, 32'd14, 2'd2, 2'd3, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 32'd15, 1'b1, 32'd15, 2'd3, 2'd3, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 32'd16, 1'b1, 32'd16, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 32'hDEAD, 1'b0, 32'd16, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 32'h55, 1'b1, 32'h55, 2'd0, 2'd0, 1'b0, 1'b1};
    tbl[19] = '{1'b1, 1'b0, 32'h66, 1'b1, 32'h66, 2'd1, 2'd0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 20; i++) begin
      s_valid = tbl[i].v;
      s_sof   = tbl[i].sof;
      s_data  = tbl[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("t6_valid[%0d]", i), s_vout, tbl[i].ev);
      chk($sformatf("t6_data[%0d]", i), s_dout, tbl[i].ed);
      chk($sformatf("t6_col[%0d]", i), s_col, tbl[i].ec);
      chk($sformatf("t6_row[%0d]", i), s_row, tbl[i].er);
      chk($sformatf("t6_done[%0d]", i), s_done, tbl[i].edone);
      chk($sformatf("t6_err[%0d]", i), s_err, tbl[i].eerr);
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;

    // 3: full 208x208 frame plus one pixel, one word per pixel
    do_reset();
    seq_err = 0;
    pulses  = 0;
    dones   = 0;
    c208    = '1;
    r208    = '1;
    b_valid = 1'b1;
    for (int i = 0; i <= 43264; i++) begin
      b_data = i;
      b_sof  = (i == 0);
      @(posedge clk);
      #1;
      if (b_vout === 1'b1) pulses++;
      if (b_done === 1'b1) dones++;
      if (i < 43264) begin
        if (b_col !== 8'(i % 208) || b_row !== 8'(i / 208)) seq_err++;
      end
      if (b_dout !== 32'(i) || b_done !== (i == 43263)) seq_err++;
      if (i == 208) begin
        c208 = b_col;
        r208 = b_row;
      end
      if (i == 43263) begin
        chk("t3_last_done", b_done, 1);
        chk("t3_last_col", b_col, 207);
        chk("t3_last_row", b_row, 207);
      end
    end
    b_valid = 1'b0;
    b_sof   = 1'b0;
    chk("t3_wrap_col", b_col, 0);
    chk("t3_wrap_row", b_row, 0);
    chk("t3_pix208_col", c208, 0);
    chk("t3_pix208_row", r208, 1);
    chk("t3_pulses", pulses, 43265);
    chk("t3_done_count", dones, 1);
    chk("t3_seq_errors", seq_err, 0);
    chk("t3_err", b_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
